// File: rtl/scatter_if.sv
// scatter_if: wide input word plus N narrow per-lane output channels on the stb/ack fabric.
interface scatter_if #(
    parameter int W = 8,
    parameter int N = 4
);
    logic [N-1:0][W-1:0] s_dat;
    logic [N-1:0]        s_msk;
    logic                s_stb;
    logic                s_ack;
    logic [N-1:0][W-1:0] m_dat;
    logic [N-1:0]        m_stb;
    logic [N-1:0]        m_ack;
    logic                busy;
    modport master (output s_dat, s_msk, s_stb, m_ack, input s_ack, m_dat, m_stb, busy);
    modport slave  (input s_dat, s_msk, s_stb, m_ack, output s_ack, m_dat, m_stb, busy);
endinterface

// File: rtl/scatter.sv
// scatter: splits one N-lane word into per-lane channels, delivered in parallel
// (ORDER=0) or strictly lowest-lane-first (ORDER=1); masked-off lanes are skipped.
module scatter #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int ORDER = 0
) (
    input logic      clk,
    input logic      rst,
    scatter_if.slave bus
);
    logic [N-1:0][W-1:0] r_dat;
    logic [N-1:0]        r_pend;
    logic [N-1:0]        w_stb;
    logic                w_take;
    // pend & (~pend + 1) keeps only the lowest pending lane
    assign w_stb     = (ORDER != 0) ? (r_pend & (~r_pend + N'(1))) : r_pend;
    assign w_take    = bus.s_stb & bus.s_ack;
    assign bus.s_ack = rst & ~|r_pend;
    assign bus.busy  = |r_pend;
    assign bus.m_stb = w_stb;
    assign bus.m_dat = r_dat;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dat  <= '0;
            r_pend <= '0;
        end else if (w_take) begin
            r_dat  <= bus.s_dat;
            r_pend <= bus.s_msk;
        end else begin
            r_pend <= r_pend & ~(w_stb & bus.m_ack);
        end
    end
endmodule

// File: tb/tb_scatter.sv
// tb_scatter: directed vector table on 8x4 instances of both orders, then a random
// soak of 5x3 instances of both orders against a queue-based delivery model.
module tb_scatter;
    localparam int NW = 5000;

    typedef struct {
        bit              ord;
        logic [3:0][7:0] dat;
        logic [3:0]      msk;
        logic [3:0]      ack;
        logic [3:0]      stb [5];
        logic            sack [5];
        string           name;
    } vec_t;

    logic clk;
    logic rst;
    bit   soak_go = 0;
    int   errors = 0;
    int   checks = 0;

    scatter_if #(.W(8), .N(4)) b0 ();
    scatter_if #(.W(8), .N(4)) b1 ();
    scatter #(.W(8), .N(4), .ORDER(0)) d0 (.clk(clk), .rst(rst), .bus(b0.slave));
    scatter #(.W(8), .N(4), .ORDER(1)) d1 (.clk(clk), .rst(rst), .bus(b1.slave));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", nm);
    endtask

    task automatic drain();
        int c;
        b0.m_ack = '1;
        b1.m_ack = '1;
        for (c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b0.s_ack && b1.s_ack) break;
        end
        if (c == 20) fail("drain timeout");
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0] stb;
        logic       sack, bsy;
        drain();
        if (v.ord) begin
            b1.s_dat = v.dat; b1.s_msk = v.msk; b1.m_ack = v.ack; b1.s_stb = 1;
        end else begin
            b0.s_dat = v.dat; b0.s_msk = v.msk; b0.m_ack = v.ack; b0.s_stb = 1;
        end
        @(posedge clk);
        #1;
        b0.s_stb = 0;
        b1.s_stb = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            stb  = v.ord ? b1.m_stb : b0.m_stb;
            sack = v.ord ? b1.s_ack : b0.s_ack;
            bsy  = v.ord ? b1.busy  : b0.busy;
            chk($sformatf("%s c%0d m_stb", v.name, c + 1), stb, v.stb[c]);
            chk($sformatf("%s c%0d s_ack", v.name, c + 1), sack, v.sack[c]);
            chk($sformatf("%s c%0d busy", v.name, c + 1), bsy, !v.sack[c]);
            for (int i = 0; i < 4; i++)
                if (v.stb[c][i])
                    chk($sformatf("%s c%0d m_dat[%0d]", v.name, c + 1, i),
                        v.ord ? b1.m_dat[i] : b0.m_dat[i], v.dat[i]);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " m_stb0"}, b0.m_stb, 4'h0);
        chk({nm, " s_ack0"}, b0.s_ack, 1'b0);
        chk({nm, " busy0"}, b0.busy, 1'b0);
        chk({nm, " m_dat0"}, b0.m_dat, 32'h0);
        chk({nm, " m_stb1"}, b1.m_stb, 4'h0);
        chk({nm, " s_ack1"}, b1.s_ack, 1'b0);
        chk({nm, " busy1"}, b1.busy, 1'b0);
        chk({nm, " m_dat1"}, b1.m_dat, 32'h0);
    endtask

    for (genvar g = 0; g < 2; g++) begin : sk
        scatter_if #(.W(5), .N(3)) b ();
        scatter #(.W(5), .N(3), .ORDER(g)) u (.clk(clk), .rst(rst), .bus(b.slave));
        logic [4:0] lq [3][$];
        int         oq [$];
        logic [2:0] es;
        int         words = 0;
        int         cnt = 0;
        bit         acc = 0;
        bit         done = 0;
        initial begin
            b.s_stb = 0; b.s_dat = '0; b.s_msk = '0; b.m_ack = '0;
            wait (soak_go);
            while (words < NW) begin
                @(posedge clk);
                #1;
                if (acc) words++;
                if (!b.s_stb || acc) begin
                    b.s_stb = (words < NW) && ($urandom_range(3) != 0);
                    b.s_dat = 15'($urandom);
                    b.s_msk = 3'($urandom);
                end
                b.m_ack = 3'($urandom | $urandom);
            end
            done = 1;
        end
        // model: per-lane FIFOs of undelivered data, plus global lane order for ORDER=1
        initial forever begin
            @(negedge clk);
            if (soak_go && rst) begin
                es = '0;
                for (int i = 0; i < 3; i++)
                    if (g == 0) es[i] = lq[i].size() != 0;
                if (g == 1 && oq.size() != 0) es[oq[0]] = 1'b1;
                chk($sformatf("soak%0d m_stb", g), b.m_stb, es);
                chk($sformatf("soak%0d s_ack", g), b.s_ack, cnt == 0);
                for (int i = 0; i < 3; i++)
                    if (es[i]) chk($sformatf("soak%0d m_dat[%0d]", g, i), b.m_dat[i], lq[i][0]);
                for (int i = 0; i < 3; i++)
                    if (es[i] && b.m_ack[i]) begin
                        void'(lq[i].pop_front());
                        if (g == 1) void'(oq.pop_front());
                    end
                acc = b.s_stb && cnt == 0;
                if (acc)
                    for (int i = 0; i < 3; i++)
                        if (b.s_msk[i]) begin
                            lq[i].push_back(b.s_dat[i]);
                            if (g == 1) oq.push_back(i);
                        end
                cnt = lq[0].size() + lq[1].size() + lq[2].size();
            end
        end
    end

    vec_t vt [8];
    vec_t rv;

    initial begin
        vt[0] = '{0, 32'h44332211, 4'hF, 4'hF, '{4'hF, 0, 0, 0, 0}, '{0, 1, 1, 1, 1}, "par full"};
        vt[1] = '{1, 32'h44332211, 4'hA, 4'hF, '{4'h2, 4'h8, 0, 0, 0}, '{0, 0, 1, 1, 1}, "ord mask"};
        vt[2] = '{0, 32'h5A5A5A5A, 4'h0, 4'hF, '{0, 0, 0, 0, 0}, '{1, 1, 1, 1, 1}, "par empty"};
        vt[3] = '{1, 32'hC3C3C3C3, 4'h0, 4'hF, '{0, 0, 0, 0, 0}, '{1, 1, 1, 1, 1}, "ord empty"};
        vt[4] = '{1, 32'hDDCCBBAA, 4'hF, 4'hF, '{4'h1, 4'h2, 4'h4, 4'h8, 0}, '{0, 0, 0, 0, 1}, "ord full"};
        vt[5] = '{0, 32'h01020304, 4'h5, 4'hF, '{4'h5, 0, 0, 0, 0}, '{0, 1, 1, 1, 1}, "par mask5"};
        vt[6] = '{1, 32'h89ABCDEF, 4'hF, 4'hD, '{4'h1, 4'h2, 4'h2, 4'h2, 4'h2}, '{0, 0, 0, 0, 0}, "ord stall"};
        vt[7] = '{0, 32'h44332211, 4'hF, 4'hB, '{4'hF, 4'h4, 4'h4, 4'h4, 4'h4}, '{0, 0, 0, 0, 0}, "par stall"};
        rst = 1;
        b0.s_stb = 0; b0.s_dat = '0; b0.s_msk = '0; b0.m_ack = '0;
        b1.s_stb = 0; b1.s_dat = '0; b1.s_msk = '0; b1.m_ack = '0;
        #3 rst = 0;
        #1 chk_reset("reset");
        @(negedge clk);
        rst = 1;
        #1;
        chk("release s_ack0", b0.s_ack, 1'b1);
        chk("release s_ack1", b1.s_ack, 1'b1);

        for (int k = 0; k < 8; k++) run_vec(vt[k]);

        // lane 2 of the parallel instance is still stalled holding 8'h33
        b0.m_ack = 4'hF;
        @(negedge clk);
        chk("par stall release m_stb", b0.m_stb, 4'h0);
        chk("par stall release s_ack", b0.s_ack, 1'b1);
        chk("par stall release busy", b0.busy, 1'b0);

        drain();
        b1.s_dat = 32'h44332211; b1.s_msk = 4'hF; b1.m_ack = 4'h1; b1.s_stb = 1;
        @(posedge clk);
        #1 b1.s_stb = 0;
        @(negedge clk);
        chk("rst mid c1 m_stb", b1.m_stb, 4'h1);
        @(negedge clk);
        chk("rst mid c2 m_stb", b1.m_stb, 4'h2);
        chk("rst mid c2 m_dat[1]", b1.m_dat[1], 8'h22);
        @(posedge clk);
        #2 rst = 0;
        #1 chk_reset("rst mid");
        @(negedge clk);
        rst = 1;
        #1 chk("rst mid release s_ack", b1.s_ack, 1'b1);
        rv = '{1, 32'hA5A5A5A5, 4'hF, 4'hF, '{4'h1, 4'h2, 4'h4, 4'h8, 0}, '{0, 0, 0, 0, 1}, "post rst"};
        run_vec(rv);

        soak_go = 1;
        for (int c = 0; c < 90000 && !(sk[0].done && sk[1].done); c++) @(negedge clk);
        if (!(sk[0].done && sk[1].done)) fail("soak timeout");
        sk[0].b.m_ack = '1;
        sk[1].b.m_ack = '1;
        for (int c = 0; c < 20 && (sk[0].cnt != 0 || sk[1].cnt != 0); c++) @(negedge clk);
        chk("soak0 residue", sk[0].cnt, 0);
        chk("soak1 residue", sk[1].cnt, 0);
        chk("soak0 words", sk[0].words, NW);
        chk("soak1 words", sk[1].words, NW);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
